twos_serializer: RTL and testbench

Upstream feeder for the bit-serial two's-complement stage. Accepts parallel words over a valid/ready handshake and shifts each one out LSB-first on a single serial line. Before every word it emits a one-cycle word-start reset strobe, so the downstream stage restarts its "first one seen" state per word. Sustained throughput is one word per W+1 clocks.

---
 rtl/twos_serializer.sv | 179 +++++++++++++++++
 tb/tb_twos_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_serializer.sv
// ============================================================================
// twos_serializer
// ----------------------------------------------------------------------------
// Upstream feeder for a bit-serial two's-complement stage. Parallel words are
// taken over a valid/ready handshake. Each word is preceded by a one-cycle
// word-start strobe, and its bits are then shifted out LSB-first. Sustained
// throughput is one word every W+1 clocks, with no idle gap between words.
//
// Optional feature macro: TWOS_SER_SKID_EN
//   Defined   : a one-word holding register lets the next word be accepted at
//               any point while the current word is busy.
//   Undefined : ready is raised only in IDLE and in the last bit cycle.
//   The serial waveform is the same in both builds.
//
// Ports
//   t_clk     in   system clock, rising edge
//   r_n       in   synchronous active-low reset
//   din       in   [W-1:0] parallel word, LSB is shifted out first
//   din_valid in   din holds a word
//   din_ready out  word accepted on an edge with din_valid & din_ready
//   so        out  serial data (downstream i input)
//   sr        out  word-start strobe (downstream r input)
//   last      out  high while so carries bit W-1
//   busy      out  high in START or SHIFT
// ============================================================================
module twos_serializer #(
   parameter int W = 8
) (
   input  logic         t_clk,
   input  logic         r_n,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         so,
   output logic         sr,
   output logic         last,
   output logic         busy
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
   localparam logic [CW-1:0] PRE_CNT  = CW'(W - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t         state_reg;
   logic [CW-1:0]  cnt_reg;
   logic [W-1:0]   shift_reg;
   logic           so_reg;
   logic           sr_reg;
   logic           last_reg;
   logic           busy_reg;
   logic           ready_reg;

   logic           xfer;
   logic           at_last;
   logic           word_avail;
   logic [W-1:0]   next_word;
   logic           ready_next;

   always_comb begin
      xfer    = din_valid & ready_reg;
      at_last = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
   end

`ifdef TWOS_SER_SKID_EN
   logic [W-1:0] hold_reg;
   logic         hold_full_reg;
   logic         load_hold;
   logic         hold_full_next;

   // A word arriving in IDLE or in the last bit cycle (the holding register is
   // necessarily empty then, otherwise ready would be low) goes straight to
   // the shift register; anything else that arrives while busy is parked.
   always_comb begin
      load_hold      = xfer && (state_reg != IDLE) && !at_last;
      hold_full_next = load_hold | (hold_full_reg & ~at_last);
      word_avail     = hold_full_reg | xfer;
      next_word      = hold_full_reg ? hold_reg : din;
      ready_next     = ~hold_full_next;
   end

   always_ff @(posedge t_clk) begin
      if (!r_n) begin
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
      end else begin
         if (load_hold) begin
            hold_reg <= din;
         end
         hold_full_reg <= hold_full_next;
      end
   end
`else
   // Ready is registered, so it is computed for the state being entered:
   // staying in IDLE, entering the last bit cycle, or leaving to IDLE.
   always_comb begin
      word_avail = xfer;
      next_word  = din;
      ready_next = ((state_reg == IDLE) && !xfer) ||
                   ((state_reg == SHIFT) && !at_last && (cnt_reg == PRE_CNT)) ||
                   (at_last && !word_avail);
   end
`endif

   // Outputs are registered together with the state, so each output value
   // is the one belonging to the state being entered.
   always_ff @(posedge t_clk) begin
      if (!r_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         shift_reg <= '0;
         so_reg    <= 1'b0;
         sr_reg    <= 1'b0;
         last_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         so_reg    <= 1'b0;
         sr_reg    <= 1'b0;
         last_reg  <= 1'b0;
         ready_reg <= ready_next;
         case (state_reg)
            IDLE: begin
               busy_reg <= 1'b0;
               if (xfer) begin
                  shift_reg <= din;
                  cnt_reg   <= '0;
                  sr_reg    <= 1'b1;
                  busy_reg  <= 1'b1;
                  state_reg <= START;
               end
            end
            START: begin
               cnt_reg   <= '0;
               so_reg    <= shift_reg[0];
               busy_reg  <= 1'b1;
               state_reg <= SHIFT;
            end
            SHIFT: begin
               if (at_last) begin
                  if (word_avail) begin
                     shift_reg <= next_word;
                     cnt_reg   <= '0;
                     sr_reg    <= 1'b1;
                     busy_reg  <= 1'b1;
                     state_reg <= START;
                  end else begin
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end else begin
                  // so already shows bit 0 of shift_reg; the next bit is [1]
                  cnt_reg   <= cnt_reg + 1'b1;
                  shift_reg <= shift_reg >> 1;
                  so_reg    <= shift_reg[1];
                  last_reg  <= (cnt_reg == PRE_CNT);
                  busy_reg  <= 1'b1;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign din_ready = ready_reg;
   assign so        = so_reg;
   assign sr        = sr_reg;
   assign last      = last_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_twos_serializer.sv
// ============================================================================
// tb_twos_serializer
// ----------------------------------------------------------------------------
// Directed bench for twos_serializer (W=8). Words are pushed to a scoreboard
// queue when they are handed to the DUT; a negedge monitor pops the queue on
// each word-start strobe, collects the following W serial bits and compares.
// Honours TWOS_SER_SKID_EN for the build-specific ready behaviour.
// ============================================================================
module tb_twos_serializer;

   localparam int W = 8;

   logic         t_clk = 1'b0;
   logic         r_n = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         din_ready;
   logic         so;
   logic         sr;
   logic         last;
   logic         busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [W-1:0] exp_q[$];
   logic         mon_active = 1'b0;
   int           mon_bit = 0;
   logic [W-1:0] mon_word = '0;
   logic [W-1:0] mon_exp = '0;

   twos_serializer #(.W(W)) dut (
      .t_clk     (t_clk),
      .r_n       (r_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .so        (so),
      .sr        (sr),
      .last      (last),
      .busy      (busy)
   );

   always #5 t_clk = ~t_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge t_clk);
      #1;
      cyc++;
   endtask

   // Reference model of the downstream complementer: copy bits up to and
   // including the first one, invert everything after it.
   function automatic logic [W-1:0] complement_model(input logic [W-1:0] bits);
      logic [W-1:0] r;
      logic seen;
      r = '0;
      seen = 1'b0;
      for (int j = 0; j < W; j++) begin
         r[j] = seen ? ~bits[j] : bits[j];
         seen = seen | bits[j];
      end
      return r;
   endfunction

   // Hand a word over; returns in the sr cycle that follows the transfer.
   task automatic send_word(input logic [W-1:0] w);
      din = w;
      din_valid = 1'b1;
      for (int i = 0; i < 20 && din_ready !== 1'b1; i++) tick();
      check("din_ready_wait", din_ready, 1);
      exp_q.push_back(w);
      tick();
      din_valid = 1'b0;
   endtask

   // Called in the sr cycle; walks the W bit cycles, ends in the last cycle.
   task automatic expect_stream(input logic [W-1:0] w, output logic [W-1:0] got);
      check("sr_start", sr, 1);
      check("busy_start", busy, 1);
      check("so_start", so, 0);
`ifndef TWOS_SER_SKID_EN
      check("ready_start", din_ready, 0);
`endif
      got = '0;
      for (int j = 0; j < W; j++) begin
         tick();
         check($sformatf("so_bit%0d", j), so, w[j]);
         check($sformatf("last_bit%0d", j), last, (j == W - 1));
         check($sformatf("sr_bit%0d", j), sr, 0);
`ifndef TWOS_SER_SKID_EN
         check($sformatf("ready_bit%0d", j), din_ready, (j == W - 1));
`endif
         got[j] = so;
      end
   endtask

   // Scoreboard monitor
   always @(negedge t_clk) begin
      if (mon_active) begin
         if (busy !== 1'b1) begin
            mon_active = 1'b0;        // word abandoned by reset
         end else begin
            mon_word[mon_bit] = so;
            check("mon_last", last, (mon_bit == W - 1));
            if (mon_bit == W - 1) begin
               check("mon_word", mon_word, mon_exp);
               mon_active = 1'b0;
            end else begin
               mon_bit++;
            end
         end
      end else if (sr === 1'b1) begin
         check("mon_sr_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
         else mon_exp = 'x;
         mon_word = '0;
         mon_bit = 0;
         mon_active = 1'b1;
      end
   end

   initial begin
      logic [W-1:0] got;
      int sr_cyc;

      // ---- Reset / idle ----
      r_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_ready", din_ready, 0);
         check("rst_so", so, 0);
         check("rst_sr", sr, 0);
         check("rst_last", last, 0);
         check("rst_busy", busy, 0);
      end
      r_n = 1'b1;
      tick();
      check("idle_ready", din_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_sr", sr, 0);
      check("idle_so", so, 0);

      // ---- Single word 8'h06 ----
      send_word(8'h06);
      expect_stream(8'h06, got);
      check("cmp_06", complement_model(got), 8'hFA);
      tick();
      check("post06_busy", busy, 0);
      check("post06_sr", sr, 0);
      check("post06_ready", din_ready, 1);

      // ---- Back-to-back 8'h01, 8'h80 ----
      din = 8'h01;
      din_valid = 1'b1;
      for (int i = 0; i < 20 && din_ready !== 1'b1; i++) tick();
      check("b2b_ready_wait", din_ready, 1);
      exp_q.push_back(8'h01);
      tick();
      sr_cyc = cyc;
      din = 8'h80;
      exp_q.push_back(8'h80);
      expect_stream(8'h01, got);
      tick();
      din_valid = 1'b0;
      check("b2b_sr_gap", cyc - sr_cyc, 9);
      expect_stream(8'h80, got);
      tick();
      check("post_b2b_busy", busy, 0);

      // ---- Reset mid-word ----
      send_word(8'hFF);
      for (int j = 0; j < 4; j++) tick();   // now in bit 3
      check("mid_so_bit3", so, 1);
      r_n = 1'b0;
      tick();
      r_n = 1'b1;
      check("mid_rst_so", so, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", din_ready, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_quiet_sr", sr, 0);
         check("mid_quiet_busy", busy, 0);
      end
      check("mid_ready_back", din_ready, 1);
      send_word(8'h02);
      expect_stream(8'h02, got);
      tick();
      check("post02_busy", busy, 0);

`ifdef TWOS_SER_SKID_EN
      // ---- Skid: 8'h3C arrives while 8'hA5 is at bit 2 ----
      send_word(8'hA5);
      check("skid_sr_a5", sr, 1);
      for (int j = 0; j < W; j++) begin
         tick();
         if (j == 3) din_valid = 1'b0;
         check($sformatf("skid_a5_bit%0d", j), so, (8'hA5 >> j) & 1);
         check($sformatf("skid_a5_last%0d", j), last, (j == W - 1));
         if (j >= 3) check($sformatf("skid_ready_bit%0d", j), din_ready, 0);
         if (j == 2) begin
            check("skid_ready_at_bit2", din_ready, 1);
            din = 8'h3C;
            din_valid = 1'b1;
            exp_q.push_back(8'h3C);
         end
      end
      tick();
      check("skid_sr_3c", sr, 1);
      check("skid_ready_start", din_ready, 1);
      for (int j = 0; j < W; j++) begin
         tick();
         check($sformatf("skid_3c_bit%0d", j), so, (8'h3C >> j) & 1);
      end
      tick();
      check("post_skid_busy", busy, 0);
`endif

      // ---- Reset / transfer collision ----
      check("coll_pre_ready", din_ready, 1);
      din = 8'h55;
      din_valid = 1'b1;
      r_n = 1'b0;
      tick();
      r_n = 1'b1;
      din_valid = 1'b0;
      check("coll_busy", busy, 0);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("coll_sr", sr, 0);
         check("coll_busy_q", busy, 0);
      end

      check("queue_drained", exp_q.size(), 0);
      check("monitor_idle", mon_active, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
